// File: rtl/rs_syndrome_calc.sv
// Streaming GF(256) Reed-Solomon syndrome generator (poly 0x11D), Horner per syndrome.
// Define RS_SYN_ERASURE_EN to add in_erase / erase_cnt erasure counting.

module gf256_mult #(
    parameter logic [7:0] B = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);
    logic [7:0] a;

    always_comb begin
        p_o = 8'h00;
        a   = a_i;
        for (int i = 0; i < 8; i++) begin
            if (B[i]) p_o = p_o ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
        end
    end
endmodule

module rs_syndrome_calc #(
    parameter int N    = 32,
    parameter int NSYN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_sof,
`ifdef RS_SYN_ERASURE_EN
    input  logic                in_erase,
    output logic [3:0]          erase_cnt,
`endif
    output logic                syn_valid,
    input  logic                syn_ready,
    output logic [8*NSYN-1:0]   syn,
    output logic                syn_zero
);
    localparam int CW = $clog2(N);

    function automatic logic [7:0] alpha_pow(input int j);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < j; i++)
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
        return v;
    endfunction

    logic [CW-1:0]            cnt_q, cnt_d, cnt_eff;
    logic [NSYN-1:0][7:0]     acc_q, acc_d, prod;
    logic [NSYN-1:0][7:0]     syn_q, syn_d;
    logic                     syn_valid_q, syn_valid_d;
    logic                     syn_zero_q, syn_zero_d;
    logic                     first, last, accept, done;

    for (genvar j = 0; j < NSYN; j++) begin : g_mul
        gf256_mult #(.B(alpha_pow(j))) u_mul (
            .a_i (acc_q[j]),
            .p_o (prod[j])
        );
    end

    always_comb begin
        // A valid SOF restarts the count, so ready is judged against index 0.
        cnt_eff     = (in_valid && in_sof) ? '0 : cnt_q;
        first       = (cnt_eff == '0);
        last        = (cnt_eff == CW'(N-1));
        in_ready    = !(last && syn_valid_q && !syn_ready);
        accept      = in_valid && in_ready;
        done        = accept && last;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        if (accept) begin
            cnt_d = last ? '0 : cnt_eff + 1'b1;
            for (int j = 0; j < NSYN; j++)
                acc_d[j] = (first ? 8'h00 : prod[j]) ^ in_data;
        end
        syn_d       = syn_q;
        syn_zero_d  = syn_zero_q;
        syn_valid_d = syn_valid_q && !syn_ready;
        if (done) begin
            syn_d       = acc_d;
            syn_zero_d  = ~|acc_d;
            syn_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            syn_q       <= '0;
            syn_valid_q <= 1'b0;
            syn_zero_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            syn_q       <= syn_d;
            syn_valid_q <= syn_valid_d;
            syn_zero_q  <= syn_zero_d;
        end
    end

    assign syn       = syn_q;
    assign syn_valid = syn_valid_q;
    assign syn_zero  = syn_zero_q;

`ifdef RS_SYN_ERASURE_EN
    logic [3:0] ecnt_q, ecnt_d, ecnt_base;
    logic [3:0] erase_cnt_q, erase_cnt_d;

    always_comb begin
        ecnt_base   = first ? 4'd0 : ecnt_q;
        ecnt_d      = ecnt_q;
        erase_cnt_d = erase_cnt_q;
        if (accept)
            ecnt_d = (in_erase && ecnt_base != 4'd15) ? ecnt_base + 4'd1 : ecnt_base;
        if (done)
            erase_cnt_d = ecnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ecnt_q      <= 4'd0;
            erase_cnt_q <= 4'd0;
        end else begin
            ecnt_q      <= ecnt_d;
            erase_cnt_q <= erase_cnt_d;
        end
    end

    assign erase_cnt = erase_cnt_q;
`endif
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Self-checking bench for rs_syndrome_calc: vector table, corner sequences, random stream.
// Reference model evaluates each codeword polynomial directly with log/exp tables.

module tb_rs_syndrome_calc;
    localparam int N    = 32;
    localparam int NSYN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_sof;
    logic              syn_valid;
    logic              syn_ready;
    logic [8*NSYN-1:0] syn;
    logic              syn_zero;
`ifdef RS_SYN_ERASURE_EN
    logic              in_erase;
    logic [3:0]        erase_cnt;
`endif

    rs_syndrome_calc #(.N(N), .NSYN(NSYN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
`ifdef RS_SYN_ERASURE_EN
        .in_erase  (in_erase),
        .erase_cnt (erase_cnt),
`endif
        .syn_valid (syn_valid),
        .syn_ready (syn_ready),
        .syn       (syn),
        .syn_zero  (syn_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] gexp [255];
    int         glog [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic init_tables();
        int v;
        v = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = v[7:0];
            glog[v] = i;
            v = v << 1;
            if ((v & 256) != 0) v = v ^ 'h11D;
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    // S_j = sum_k c_k * alpha^(j*(N-1-k))
    function automatic logic [8*NSYN-1:0] ref_syn(input logic [7:0] cw[$]);
        logic [8*NSYN-1:0] r;
        logic [7:0]        s;
        r = '0;
        for (int j = 0; j < NSYN; j++) begin
            s = 8'h00;
            for (int k = 0; k < N; k++)
                s = s ^ gmul(cw[k], gexp[(j * (N - 1 - k)) % 255]);
            r[8*j +: 8] = s;
        end
        return r;
    endfunction

    // Presents one symbol and returns at posedge+1 after it is accepted.
    task automatic send_sym(input logic [7:0] d, input logic s, input logic e, output bit stalled);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
`ifdef RS_SYN_ERASURE_EN
        in_erase = e;
`else
        if (e) in_data = d;
`endif
        stalled = 1'b0;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            stalled = 1'b1;
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_sof = 1'b0;
`ifdef RS_SYN_ERASURE_EN
        in_erase = 1'b0;
`endif
    endtask

    task automatic send_impulse(input int pos, input logic [7:0] val, output bit anystall);
        bit st;
        anystall = 1'b0;
        for (int k = 0; k < N; k++) begin
            send_sym((k == pos) ? val : 8'h00, k == 0, 1'b0, st);
            anystall |= st;
        end
    endtask

    typedef struct {
        int                pos;
        logic [7:0]        val;
        logic [8*NSYN-1:0] syn;
        logic              zero;
    } vec_t;

    vec_t            vt [6];
    logic [7:0]      cw [$];
    logic [8*NSYN-1:0] expq [$];
    logic [8*NSYN-1:0] e;
    logic            exp_ready;
    bit              st, anyst, seen;

    initial begin
        init_tables();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sof    = 1'b0;
        syn_ready = 1'b1;
`ifdef RS_SYN_ERASURE_EN
        in_erase  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_syn_valid", syn_valid, 0);
        chk("reset_syn", syn, 0);
        chk("reset_syn_zero", syn_zero, 0);
        chk("reset_in_ready", in_ready, 1);
`ifdef RS_SYN_ERASURE_EN
        chk("reset_erase_cnt", erase_cnt, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        vt[0] = '{pos: 0,  val: 8'h00, syn: 32'h00000000, zero: 1'b1};
        vt[1] = '{pos: 31, val: 8'h01, syn: 32'h01010101, zero: 1'b0};
        vt[2] = '{pos: 30, val: 8'h01, syn: 32'h08040201, zero: 1'b0};
        vt[3] = '{pos: 29, val: 8'h01, syn: 32'h40100401, zero: 1'b0};
        vt[4] = '{pos: 31, val: 8'h53, syn: 32'h53535353, zero: 1'b0};
        vt[5] = '{pos: 30, val: 8'h80, syn: 32'h743A1D80, zero: 1'b0};
        for (int i = 0; i < 6; i++) begin
            send_impulse(vt[i].pos, vt[i].val, anyst);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), syn_valid, 1);
            chk($sformatf("vec%0d_syn", i), syn, vt[i].syn);
            chk($sformatf("vec%0d_zero", i), syn_zero, vt[i].zero);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_consumed", i), syn_valid, 0);
        end

        // Back-pressure: second word stalls only on its last symbol.
        syn_ready = 1'b0;
        send_impulse(31, 8'h01, anyst);
        chk("bp_a_valid", syn_valid, 1);
        chk("bp_a_syn", syn, 32'h01010101);
        anyst = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            send_sym((k == 30) ? 8'h01 : 8'h00, k == 0, 1'b0, st);
            anyst |= st;
        end
        chk("bp_no_early_stall", anyst, 0);
        in_data = 8'h00;
        #1;
        chk("bp_last_stall", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_still_stalled", in_ready, 0);
        chk("bp_hold_syn", syn, 32'h01010101);
        syn_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_b_valid", syn_valid, 1);
        chk("bp_b_syn", syn, 32'h08040201);
        @(posedge clk);
        #1;
        chk("bp_drained", syn_valid, 0);

        // SOF arriving while index N-1 waits on a full output.
        syn_ready = 1'b0;
        send_impulse(0, 8'h00, anyst);
        for (int k = 0; k < N - 1; k++) send_sym(8'h77, k == 0, 1'b0, st);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 8'h01;
        #1;
        chk("sof_pending_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_sof   = 1'b0;
        in_valid = 1'b0;
        chk("sof_pending_hold_valid", syn_valid, 1);
        chk("sof_pending_hold_syn", syn, 0);
        chk("sof_pending_hold_zero", syn_zero, 1);
        syn_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("sof_pending_drain", syn_valid, 0);
        cw.delete();
        cw.push_back(8'h01);
        for (int k = 1; k < N; k++) begin
            send_sym(8'h00, 1'b0, 1'b0, st);
            cw.push_back(8'h00);
        end
        in_valid = 1'b0;
        chk("sof_pending_new_syn", syn, ref_syn(cw));
        @(posedge clk);
        #1;

        // Resync at symbol 10: only the 32 symbols after it produce output.
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            send_sym(8'h55, k == 0, 1'b0, st);
            seen |= syn_valid;
        end
        cw.delete();
        for (int k = 0; k < N; k++) begin
            cw.push_back(8'($urandom));
            send_sym(cw[k], k == 0, 1'b0, st);
            if (k < N - 1) seen |= syn_valid;
        end
        in_valid = 1'b0;
        chk("resync_no_stray", seen, 0);
        chk("resync_valid", syn_valid, 1);
        chk("resync_syn", syn, ref_syn(cw));
        @(posedge clk);
        #1;
        chk("resync_single", syn_valid, 0);

        // Reset mid-codeword with a word pending.
        syn_ready = 1'b0;
        send_impulse(31, 8'h01, anyst);
        for (int k = 0; k < 15; k++) send_sym(8'h33, 1'b0, 1'b0, st);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", syn_valid, 0);
        chk("midrst_syn", syn, 0);
        chk("midrst_zero", syn_zero, 0);
        chk("midrst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        syn_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 17; k++) begin
            send_sym(8'h00, 1'b0, 1'b0, st);
            seen |= syn_valid;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        seen |= syn_valid;
        chk("midrst_no_stray", seen, 0);
        for (int k = 0; k < 15; k++) send_sym(8'h00, 1'b0, 1'b0, st);
        in_valid = 1'b0;
        chk("midrst_restart_valid", syn_valid, 1);
        chk("midrst_restart_zero", syn_zero, 1);
        @(posedge clk);
        #1;

`ifdef RS_SYN_ERASURE_EN
        for (int k = 0; k < N; k++)
            send_sym(8'h00, k == 0, (k == 2 || k == 5 || k == 9), st);
        in_valid = 1'b0;
        chk("erase_three", erase_cnt, 3);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) send_sym(8'h00, k == 0, k < 20, st);
        in_valid = 1'b0;
        chk("erase_saturate", erase_cnt, 15);
        @(posedge clk);
        #1;
`endif

        // Random stream against the polynomial-evaluation model.
        cw.delete();
        expq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_sof    = in_valid && ($urandom_range(0, 39) == 0);
            syn_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            exp_ready = (in_valid && in_sof) ? 1'b1
                      : !(cw.size() == N - 1 && expq.size() > 0 && !syn_ready);
            chk("rnd_in_ready", in_ready, exp_ready);
            chk("rnd_syn_valid", syn_valid, expq.size() > 0);
            if (syn_ready && expq.size() > 0) begin
                chk("rnd_syn", syn, expq[0]);
                chk("rnd_syn_zero", syn_zero, expq[0] == '0);
                void'(expq.pop_front());
            end
            if (in_valid && exp_ready) begin
                if (in_sof) cw.delete();
                cw.push_back(in_data);
                if (cw.size() == N) begin
                    e = ref_syn(cw);
                    expq.push_back(e);
                    cw.delete();
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        syn_ready = 1'b1;
        @(negedge clk);
        if (expq.size() > 0) begin
            chk("rnd_final_syn", syn, expq[0]);
            void'(expq.pop_front());
        end
        @(posedge clk);
        #1;
        chk("rnd_final_empty", syn_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Streaming syndrome generator for the CIRC Reed-Solomon decoder over GF(256), field polynomial 0x11D. It accepts one received codeword symbol per cycle, highest-degree coefficient first. It evaluates the codeword at alpha^0..alpha^(NSYN-1) by Horner's rule, using one constant-operand `gf256_mult` per syndrome. It sits directly upstream of the key-equation/error-locator stage, which consumes its packed syndromes through a valid/ready handshake.

## Interface
- `N`, 32: symbols per codeword (32 for C1, 28 for C2); legal range 2..255.
- `NSYN`, 4: number of syndromes (parity symbols); legal range 1..8.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  symbol present on `in_data`.
- `in_ready`  out  1  block can accept a symbol this cycle.
- `in_data`  in  8  received symbol.
- `in_sof`  in  1  qualified by `in_valid`; marks the first symbol of a codeword.
- `syn_valid`  out  1  syndrome word held on `syn`.
- `syn_ready`  in  1  downstream accepts `syn`.
- `syn`  out  8*NSYN  syndromes, packed: S_j in bits [8j+7:8j].
- `syn_zero`  out  1  all syndromes are zero; qualified by `syn_valid`.
- `erase_cnt`  out  4  erasure count; present only with `RS_SYN_ERASURE_EN`.
- `in_erase`  in  1  erasure flag for `in_data`; present only with `RS_SYN_ERASURE_EN`.

## Operation
- A symbol is accepted when `in_valid && in_ready`.
- Symbol index counter `cnt` runs 0..N-1. Symbol k is the coefficient of x^(N-1-k).
- Accumulators: for each j, `acc_j <= (cnt==0 ? 8'h00 : gf_mul(acc_j, alpha^j)) ^ in_data` on each accept.
- The alpha^j constants are fixed at elaboration: alpha = 0x02, so alpha^0..3 = 01, 02, 04, 08.
- All arithmetic is GF(256) XOR/multiply. There is no integer carry anywhere.
- Accepting the symbol with `cnt==N-1` completes the codeword:
  - the final accumulator values go into the output register;
  - `syn_valid` sets;
  - `cnt` returns to 0.
- `syn_zero` = NOR of all output syndrome bits; it is registered with `syn`.
- Output register states:
  - EMPTY: `syn_valid`=0.
  - FULL: `syn_valid`=1. Goes to EMPTY on `syn_ready`, or is reloaded by a completing symbol in the same cycle.
- Back-pressure: `in_ready` = !(cnt==N-1 && syn_valid && !syn_ready). Only the last symbol of a codeword stalls. Symbols 0..N-2 of the next codeword accumulate while the previous result waits.
- `in_sof` on an accepted symbol forces `cnt` to 0 for that symbol. Any partial codeword is discarded silently and no output is produced for it.
- `in_sof` while `cnt==N-1` is already pending:
  - the `in_sof` symbol starts a new codeword;
  - nothing completes;
  - `in_ready` follows `cnt` after the forced reset, so the block must not stall. It computes `in_ready` as if `cnt` were 0 when `in_valid && in_sof`.
- `in_sof` is not required on the first codeword after reset, because `cnt` resets to 0.
- Reset mid-codeword: all partial state is lost and no output is emitted.

## Timing
- Reset values: `syn_valid`=0, `syn`=0, `syn_zero`=0, `erase_cnt`=0, `in_ready`=1. Internally `cnt`=0 and all accumulators are 0.
- Throughput: one symbol per cycle with no bubbles between codewords while `syn_ready` stays high.
- Latency: `syn_valid` rises on the clock edge that accepts symbol N-1, so results are visible the cycle after the last accept.
- `syn` and `syn_zero` hold stable while `syn_valid && !syn_ready`.
- Simultaneous `syn_ready` and completing accept: the old word is consumed, the new word is loaded, and `syn_valid` stays 1.
- Combinational path: one `gf256_mult` plus an XOR per accumulator, between registers.

## Configuration
- `RS_SYN_ERASURE_EN` defined:
  - adds `in_erase` and `erase_cnt`;
  - counts erased symbols per codeword, saturating at 15;
  - the count is loaded into `erase_cnt` alongside `syn` and follows the same reset, `in_sof` and hold rules.
- `RS_SYN_ERASURE_EN` undefined: the ports and counter are absent, and behaviour is otherwise identical.

## Test plan
- Zero codeword: N=32, all symbols 0x00 -> `syn`=32'h0, `syn_zero`=1, `syn_valid` the cycle after the 32nd accept.
- Degree-0 impulse: only symbol 31 = 0x01 -> S0..S3 = 01, 01, 01, 01; `syn`=32'h01010101; `syn_zero`=0.
- Degree-1 impulse: only symbol 30 = 0x01 -> S0..S3 = 01, 02, 04, 08; `syn`=32'h08040201.
- Back-pressure: two back-to-back codewords with `syn_ready`=0 held -> `in_ready` drops only at symbol 31 of the second codeword. Raising `syn_ready` consumes word 1 and loads word 2 in the same cycle.
- Resync: `in_sof` asserted on symbol 10 of a codeword, then 31 more symbols -> exactly one output, equal to the syndromes of the 32 symbols after resync. Also assert `rst` mid-codeword -> outputs return to reset values and no stray `syn_valid`.
- Erasure (with `RS_SYN_ERASURE_EN`): 3 symbols flagged -> `erase_cnt`=3. With 20 flagged -> `erase_cnt`=15.
